// File: rtl/i2c_pkg.sv
// Shared encodings for the byte-level I2C master: FSM state codes and
// open-drain line levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START_A = 4'd1,
    S_START_B = 4'd2,
    S_BIT_LO  = 4'd3,
    S_BIT_HI  = 4'd4,
    S_ACK_LO  = 4'd5,
    S_ACK_HI  = 4'd6,
    S_DONE    = 4'd7,
    S_STOP_A  = 4'd8,
    S_STOP_B  = 4'd9,
    S_STOP_C  = 4'd10
  } state_t;

  localparam logic LINE_RELEASE = 1'b1;
  localparam logic LINE_DRIVE   = 1'b0;

  // Steps that have released SCL and must see it high before moving on.
  function automatic logic waits_scl_high(state_t s, logic [1:0] ph);
    case (s)
      S_START_A:                    return ph == 2'd2;
      S_BIT_HI, S_ACK_HI, S_STOP_B: return ph == 2'd1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator: counts 0..QDIV-1 while enabled and
// emits a one-cycle tick on the last count.
module i2c_tick_gen #(
  parameter int QDIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(QDIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en)          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: per accepted go performs START/repeated-START + one
// byte (write or read with 9th-bit handshake) or a STOP, then pulses ACK/NACK/TO.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int QDIV    = 250,
  parameter int TIMEOUT = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       go,
  input  logic       start,
  input  logic       stop,
  input  logic       RW,
  input  logic       last,
  input  logic [7:0] dataW,
  output logic [7:0] dataR,
  output logic       ACK,
  output logic       NACK,
  output logic       TO,
  output logic       busy,
  output logic [3:0] state,
  input  logic       SDA_i,
  output logic       SDA_t,
  output logic       SDA_o,
  input  logic       SCL_i,
  output logic       SCL_t,
  output logic       SCL_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        st;
  logic [1:0]    ph;
  logic [7:0]    sh;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          c_rw, c_last, owned, ack_bit;
  logic [1:0]    sda_sync, scl_sync;
  logic          sda_s, scl_s, tick, accept, waiting, timed_out;

  assign SDA_o     = 1'b0;
  assign SCL_o     = 1'b0;
  assign state     = st;
  assign sda_s     = sda_sync[1];
  assign scl_s     = scl_sync[1];
  assign accept    = go && !busy;
  assign waiting   = waits_scl_high(st, ph);
  assign timed_out = waiting && !scl_s && (to_cnt == TW'(TIMEOUT - 1));

  i2c_tick_gen #(.QDIV(QDIV)) u_tick (
    .clk  (clock),
    .rst_n(reset_n),
    .en   (busy),
    .clr  (accept),
    .tick (tick)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sda_sync <= 2'b11;
      scl_sync <= 2'b11;
    end else begin
      sda_sync <= {sda_sync[0], SDA_i};
      scl_sync <= {scl_sync[0], SCL_i};
    end
  end

  // Counts cycles a released SCL is still seen low (slave clock stretching).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          to_cnt <= '0;
    else if (waiting && !scl_s && !timed_out) to_cnt <= to_cnt + 1'b1;
    else                                   to_cnt <= '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st      <= S_IDLE;
      ph      <= 2'd0;
      busy    <= 1'b0;
      ACK     <= 1'b0;
      NACK    <= 1'b0;
      TO      <= 1'b0;
      dataR   <= 8'h00;
      SDA_t   <= LINE_RELEASE;
      SCL_t   <= LINE_RELEASE;
      owned   <= 1'b0;
      sh      <= 8'h00;
      bit_cnt <= 3'd0;
      c_rw    <= 1'b0;
      c_last  <= 1'b0;
      ack_bit <= 1'b1;
    end else begin
      // NOTE: status pulses default low every cycle; the branches below raise them for one.
      ACK  <= 1'b0;
      NACK <= 1'b0;
      TO   <= 1'b0;
      if (st == S_IDLE) begin
        if (accept) begin
          busy    <= 1'b1;
          c_rw    <= RW;
          c_last  <= last;
          sh      <= dataW;
          ph      <= 2'd0;
          bit_cnt <= 3'd0;
          st      <= stop ? S_STOP_A : (start ? S_START_A : S_BIT_LO);
        end
      end else if (timed_out) begin
        TO      <= 1'b1;
        busy    <= 1'b0;
        SDA_t   <= LINE_RELEASE;
        SCL_t   <= LINE_RELEASE;
        owned   <= 1'b0;
        bit_cnt <= 3'd0;
        ph      <= 2'd0;
        st      <= S_IDLE;
      end else if (tick) begin
        case (st)
          S_START_A: begin
            // Owned bus: free SDA while SCL is still low, then raise SCL.
            if (ph == 2'd0) begin
              SDA_t <= LINE_RELEASE;
              if (owned) ph <= 2'd1;
              else begin
                SCL_t <= LINE_RELEASE;
                ph    <= 2'd2;
              end
            end else if (ph == 2'd1) begin
              SCL_t <= LINE_RELEASE;
              ph    <= 2'd2;
            end else if (scl_s) begin
              ph <= 2'd0;
              st <= S_START_B;
            end
          end
          S_START_B: begin
            SDA_t <= LINE_DRIVE;
            owned <= 1'b1;
            st    <= S_BIT_LO;
          end
          S_BIT_LO: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_DRIVE;
              ph    <= 2'd1;
            end else begin
              SDA_t <= c_rw ? LINE_RELEASE : sh[7];
              ph    <= 2'd0;
              st    <= S_BIT_HI;
            end
          end
          S_BIT_HI: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_RELEASE;
              ph    <= 2'd1;
            end else if (scl_s) begin
              sh      <= {sh[6:0], sda_s};
              bit_cnt <= bit_cnt + 1'b1;
              ph      <= 2'd0;
              st      <= (bit_cnt == 3'd7) ? S_ACK_LO : S_BIT_LO;
            end
          end
          S_ACK_LO: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_DRIVE;
              ph    <= 2'd1;
            end else begin
              SDA_t <= c_rw ? c_last : LINE_RELEASE;
              ph    <= 2'd0;
              st    <= S_ACK_HI;
            end
          end
          S_ACK_HI: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_RELEASE;
              ph    <= 2'd1;
            end else if (scl_s) begin
              ack_bit <= sda_s;
              ph      <= 2'd0;
              st      <= S_DONE;
            end
          end
          S_DONE: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_DRIVE;
              ph    <= 2'd1;
            end else begin
              SDA_t <= LINE_RELEASE;
              busy  <= 1'b0;
              ph    <= 2'd0;
              st    <= S_IDLE;
              if (c_rw) begin
                dataR <= sh;
                ACK   <= 1'b1;
              end else if (ack_bit) NACK <= 1'b1;
              else                  ACK  <= 1'b1;
            end
          end
          S_STOP_A: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_DRIVE;
              ph    <= 2'd1;
            end else begin
              SDA_t <= LINE_DRIVE;
              ph    <= 2'd0;
              st    <= S_STOP_B;
            end
          end
          S_STOP_B: begin
            if (ph == 2'd0) begin
              SCL_t <= LINE_RELEASE;
              ph    <= 2'd1;
            end else if (scl_s) begin
              ph <= 2'd0;
              st <= S_STOP_C;
            end
          end
          S_STOP_C: begin
            SDA_t <= LINE_RELEASE;
            owned <= 1'b0;
            ACK   <= 1'b1;
            busy  <= 1'b0;
            st    <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule
